eco32f_bus_arbiter: RTL and testbench

Shares one external Wishbone-style master port between the instruction fetch bus (ibus) and the load/store bus (dbus) of the eco32f core. Fixed priority favours dbus so that the memory stage is not held in lsu_stall. A starvation guard bounds how long fetch can be locked out. The block sits between the fetch/LSU units and the system bus and serialises one transfer at a time.

---
 rtl/eco32f_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_eco32f_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eco32f_bus_arbiter.sv
// Two-requester Wishbone arbiter for the eco32f core: dbus has fixed priority,
// a starvation counter forces an ibus grant after STARVE_LIMIT dbus wins.
module eco32f_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ibus_req,
    input  logic [31:0] ibus_adr,
    output logic        ibus_ack,
    output logic        ibus_err,
    output logic [31:0] ibus_rdata,

    input  logic        dbus_req,
    input  logic        dbus_we,
    input  logic [3:0]  dbus_sel,
    input  logic [31:0] dbus_adr,
    input  logic [31:0] dbus_wdata,
    output logic        dbus_ack,
    output logic        dbus_err,
    output logic [31:0] dbus_rdata,

    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    input  logic        wb_err
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;

    logic        wb_cyc_q, wb_cyc_d;
    logic        wb_we_q, wb_we_d;
    logic [3:0]  wb_sel_q, wb_sel_d;
    logic [31:0] wb_adr_q, wb_adr_d;
    logic [31:0] wb_dat_q, wb_dat_d;

    logic        ibus_ack_q, ibus_ack_d;
    logic        ibus_err_q, ibus_err_d;
    logic [31:0] ibus_rdata_q, ibus_rdata_d;
    logic        dbus_ack_q, dbus_ack_d;
    logic        dbus_err_q, dbus_err_d;
    logic [31:0] dbus_rdata_q, dbus_rdata_d;

    // A request is stale in the cycle its own completion pulse is visible.
    logic ibus_live, dbus_live, starve_full, slave_done;

    always_comb begin
        ibus_live   = ibus_req & ~ibus_ack_q & ~ibus_err_q;
        dbus_live   = dbus_req & ~dbus_ack_q & ~dbus_err_q;
        starve_full = (starve_q == LIMIT);
        slave_done  = wb_ack | wb_err;
    end

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        wb_cyc_d     = wb_cyc_q;
        wb_we_d      = wb_we_q;
        wb_sel_d     = wb_sel_q;
        wb_adr_d     = wb_adr_q;
        wb_dat_d     = wb_dat_q;
        ibus_ack_d   = 1'b0;
        ibus_err_d   = 1'b0;
        ibus_rdata_d = ibus_rdata_q;
        dbus_ack_d   = 1'b0;
        dbus_err_d   = 1'b0;
        dbus_rdata_d = dbus_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (dbus_live && !(ibus_live && starve_full)) begin
                    state_d  = DBUS;
                    wb_cyc_d = 1'b1;
                    wb_we_d  = dbus_we;
                    wb_sel_d = dbus_sel;
                    wb_adr_d = dbus_adr;
                    wb_dat_d = dbus_wdata;
                    if (ibus_live && !starve_full) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (ibus_live) begin
                    state_d  = IBUS;
                    wb_cyc_d = 1'b1;
                    wb_we_d  = 1'b0;
                    wb_sel_d = 4'hf;
                    wb_adr_d = ibus_adr;
                    starve_d = 4'd0;
                end
            end
            IBUS: begin
                if (slave_done) begin
                    state_d  = IDLE;
                    wb_cyc_d = 1'b0;
                    // err dominates a simultaneous ack and leaves rdata untouched
                    if (wb_err) begin
                        ibus_err_d = 1'b1;
                    end else begin
                        ibus_ack_d   = 1'b1;
                        ibus_rdata_d = wb_dat_i;
                    end
                end
            end
            DBUS: begin
                if (slave_done) begin
                    state_d  = IDLE;
                    wb_cyc_d = 1'b0;
                    if (wb_err) begin
                        dbus_err_d = 1'b1;
                    end else begin
                        dbus_ack_d   = 1'b1;
                        dbus_rdata_d = wb_dat_i;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                wb_cyc_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_q     <= 4'd0;
            wb_cyc_q     <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_sel_q     <= 4'h0;
            wb_adr_q     <= 32'h0;
            wb_dat_q     <= 32'h0;
            ibus_ack_q   <= 1'b0;
            ibus_err_q   <= 1'b0;
            ibus_rdata_q <= 32'h0;
            dbus_ack_q   <= 1'b0;
            dbus_err_q   <= 1'b0;
            dbus_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            wb_cyc_q     <= wb_cyc_d;
            wb_we_q      <= wb_we_d;
            wb_sel_q     <= wb_sel_d;
            wb_adr_q     <= wb_adr_d;
            wb_dat_q     <= wb_dat_d;
            ibus_ack_q   <= ibus_ack_d;
            ibus_err_q   <= ibus_err_d;
            ibus_rdata_q <= ibus_rdata_d;
            dbus_ack_q   <= dbus_ack_d;
            dbus_err_q   <= dbus_err_d;
            dbus_rdata_q <= dbus_rdata_d;
        end
    end

    assign wb_cyc     = wb_cyc_q;
    assign wb_stb     = wb_cyc_q;
    assign wb_we      = wb_we_q;
    assign wb_sel     = wb_sel_q;
    assign wb_adr     = wb_adr_q;
    assign wb_dat_o   = wb_dat_q;
    assign ibus_ack   = ibus_ack_q;
    assign ibus_err   = ibus_err_q;
    assign ibus_rdata = ibus_rdata_q;
    assign dbus_ack   = dbus_ack_q;
    assign dbus_err   = dbus_err_q;
    assign dbus_rdata = dbus_rdata_q;

endmodule

// File: tb/tb_eco32f_bus_arbiter.sv
// Directed bench for eco32f_bus_arbiter: table of single transfers plus
// hand-written contention, starvation and reset sequences.
module tb_eco32f_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_req;
    logic [31:0] ibus_adr;
    logic        ibus_ack, ibus_err;
    logic [31:0] ibus_rdata;
    logic        dbus_req, dbus_we;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_adr, dbus_wdata;
    logic        dbus_ack, dbus_err;
    logic [31:0] dbus_rdata;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic        wb_ack, wb_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    eco32f_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .ibus_req(ibus_req), .ibus_adr(ibus_adr), .ibus_ack(ibus_ack),
        .ibus_err(ibus_err), .ibus_rdata(ibus_rdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_sel(dbus_sel),
        .dbus_adr(dbus_adr), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
        .dbus_err(dbus_err), .dbus_rdata(dbus_rdata),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] rdat;
        int          waits;
        logic        s_ack;
        logic        s_err;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic cyc, input logic we,
                           input logic [3:0] sel, input logic [31:0] adr);
        chk({tag, ".wb_cyc"}, 32'(wb_cyc), 32'(cyc));
        chk({tag, ".wb_stb"}, 32'(wb_stb), 32'(cyc));
        chk({tag, ".wb_we"},  32'(wb_we),  32'(we));
        chk({tag, ".wb_sel"}, 32'(wb_sel), 32'(sel));
        chk({tag, ".wb_adr"}, wb_adr, adr);
    endtask

    task automatic chk_pulses(input string tag, input logic ia, input logic ie,
                              input logic da, input logic de);
        chk({tag, ".ibus_ack"}, 32'(ibus_ack), 32'(ia));
        chk({tag, ".ibus_err"}, 32'(ibus_err), 32'(ie));
        chk({tag, ".dbus_ack"}, 32'(dbus_ack), 32'(da));
        chk({tag, ".dbus_err"}, 32'(dbus_err), 32'(de));
    endtask

    task automatic slave_reply(input logic a, input logic e, input logic [31:0] d);
        wb_ack = a; wb_err = e; wb_dat_i = d;
        tick();
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = 32'hCAFE_F00D;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (v.is_d) begin
            dbus_req = 1'b1; dbus_we = v.we; dbus_sel = v.sel;
            dbus_adr = v.adr; dbus_wdata = v.wdata;
            ibus_adr = 32'hBADB_AD00;
        end else begin
            ibus_req = 1'b1; ibus_adr = v.adr;
            dbus_we = 1'b1; dbus_sel = 4'h5; dbus_adr = 32'h5555_0000;
            dbus_wdata = 32'h7777_7777;
        end
        tick();
        chk_bus({tag, ".grant"}, 1'b1, v.exp_we, v.exp_sel, v.adr);
        if (v.is_d) chk({tag, ".wb_dat_o"}, wb_dat_o, v.wdata);
        for (int w = 0; w < v.waits; w++) begin
            tick();
            chk_bus({tag, ".wait"}, 1'b1, v.exp_we, v.exp_sel, v.adr);
            if (v.is_d) chk({tag, ".wait.wb_dat_o"}, wb_dat_o, v.wdata);
            chk_pulses({tag, ".wait"}, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        slave_reply(v.s_ack, v.s_err, v.rdat);
        chk({tag, ".done.wb_cyc"}, 32'(wb_cyc), 32'd0);
        if (v.is_d) begin
            chk_pulses({tag, ".done"}, 1'b0, 1'b0, v.exp_ack, v.exp_err);
            chk({tag, ".dbus_rdata"}, dbus_rdata, v.exp_rdata);
        end else begin
            chk_pulses({tag, ".done"}, v.exp_ack, v.exp_err, 1'b0, 1'b0);
            chk({tag, ".ibus_rdata"}, ibus_rdata, v.exp_rdata);
        end
        // req still held this cycle: it is stale and must not start a new cycle
        tick();
        ibus_req = 1'b0; dbus_req = 1'b0;
        chk({tag, ".stale.wb_cyc"}, 32'(wb_cyc), 32'd0);
        chk_pulses({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("xfer %0d: %s adr=%h ack=%0b err=%0b waits=%0d", idx,
                 v.is_d ? "dbus" : "ibus", v.adr, v.exp_ack, v.exp_err, v.waits);
    endtask

    initial begin
        // is_d we sel adr wdata rdat waits s_ack s_err exp_we exp_sel exp_ack exp_err exp_rdata
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 1'b0,
                    1'b0, 4'hf, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0010, 32'h0000_1234, 32'hAAAA_5555, 0, 1'b1, 1'b0,
                    1'b1, 4'h3, 1'b1, 1'b0, 32'hAAAA_5555};
        vecs[2] = '{1'b1, 1'b0, 4'hf, 32'h2000_0040, 32'h0101_0101, 32'h0BAD_F00D, 5, 1'b1, 1'b0,
                    1'b0, 4'hf, 1'b1, 1'b0, 32'h0BAD_F00D};
        vecs[3] = '{1'b1, 1'b0, 4'hf, 32'h2000_0044, 32'h0, 32'h1111_2222, 0, 1'b1, 1'b1,
                    1'b0, 4'hf, 1'b0, 1'b1, 32'h0BAD_F00D};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0000_1004, 32'h0, 32'h3333_4444, 0, 1'b0, 1'b1,
                    1'b0, 4'hf, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, 32'h1357_9BDF, 2, 1'b1, 1'b0,
                    1'b0, 4'hf, 1'b1, 1'b0, 32'h1357_9BDF};
        vecs[6] = '{1'b1, 1'b1, 4'h8, 32'h8000_0003, 32'h9900_0000, 32'h4444_5555, 1, 1'b0, 1'b1,
                    1'b1, 4'h8, 1'b0, 1'b1, 32'h0BAD_F00D};

        rst = 1'b1;
        ibus_req = 1'b0; ibus_adr = 32'h0;
        dbus_req = 1'b0; dbus_we = 1'b0; dbus_sel = 4'h0; dbus_adr = 32'h0; dbus_wdata = 32'h0;
        wb_dat_i = 32'h0; wb_ack = 1'b0; wb_err = 1'b0;
        tick(); tick();
        chk_bus("reset", 1'b0, 1'b0, 4'h0, 32'h0);
        chk("reset.wb_dat_o", wb_dat_o, 32'h0);
        chk_pulses("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.ibus_rdata", ibus_rdata, 32'h0);
        chk("reset.dbus_rdata", dbus_rdata, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Contention: dbus first, one IDLE cycle, then ibus.
        dbus_req = 1'b1; dbus_we = 1'b1; dbus_sel = 4'h3; dbus_adr = 32'h10; dbus_wdata = 32'h1234;
        ibus_req = 1'b1; ibus_adr = 32'h0000_3000;
        tick();
        chk_bus("cont.d", 1'b1, 1'b1, 4'h3, 32'h10);
        chk("cont.d.wb_dat_o", wb_dat_o, 32'h1234);
        slave_reply(1'b1, 1'b0, 32'h5555_AAAA);
        chk("cont.idle.wb_cyc", 32'(wb_cyc), 32'd0);
        chk_pulses("cont.d.done", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        dbus_req = 1'b0;
        chk_bus("cont.i", 1'b1, 1'b0, 4'hf, 32'h0000_3000);
        chk_pulses("cont.i.grant", 1'b0, 1'b0, 1'b0, 1'b0);
        slave_reply(1'b1, 1'b0, 32'h0000_600D);
        chk_pulses("cont.i.done", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("cont.ibus_rdata", ibus_rdata, 32'h0000_600D);
        tick();
        ibus_req = 1'b0;
        chk("cont.end.wb_cyc", 32'(wb_cyc), 32'd0);
        $display("xfer contention: dbus then ibus");

        // Starvation: four dbus grants won against a pending ibus_req fill the
        // counter; ibus is dropped after each grant so the counter can climb.
        ibus_adr = 32'h0000_4000;
        dbus_we = 1'b0; dbus_sel = 4'hf;
        for (int k = 0; k < 4; k++) begin
            dbus_req = 1'b1; ibus_req = 1'b1; dbus_adr = 32'h100 + 32'(k * 4);
            tick();
            ibus_req = 1'b0;
            chk_bus($sformatf("starve.d%0d", k), 1'b1, 1'b0, 4'hf, 32'h100 + 32'(k * 4));
            slave_reply(1'b1, 1'b0, 32'(k));
            chk_pulses($sformatf("starve.d%0d.done", k), 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            dbus_req = 1'b0;
            $display("xfer starve dbus grant %0d", k);
        end
        dbus_req = 1'b1; ibus_req = 1'b1; dbus_adr = 32'h200;
        tick();
        chk_bus("starve.forced_i", 1'b1, 1'b0, 4'hf, 32'h0000_4000);
        slave_reply(1'b1, 1'b0, 32'h0000_0F0F);
        chk_pulses("starve.i.done", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        ibus_req = 1'b0;
        chk_bus("starve.d_resume", 1'b1, 1'b0, 4'hf, 32'h200);
        slave_reply(1'b1, 1'b0, 32'h0);
        chk_pulses("starve.resume.done", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        dbus_req = 1'b0;
        // counter was cleared by the ibus grant, so dbus wins again
        dbus_req = 1'b1; ibus_req = 1'b1; dbus_adr = 32'h300;
        tick();
        chk_bus("starve.cleared", 1'b1, 1'b0, 4'hf, 32'h300);
        slave_reply(1'b1, 1'b0, 32'h0);
        tick();
        dbus_req = 1'b0;
        chk_bus("starve.then_i", 1'b1, 1'b0, 4'hf, 32'h0000_4000);
        slave_reply(1'b1, 1'b0, 32'h0);
        tick();
        ibus_req = 1'b0;
        $display("xfer starvation sequence complete");

        // Reset mid-transfer, then a late slave ack in IDLE.
        ibus_req = 1'b1; ibus_adr = 32'h0000_5000;
        tick();
        chk("rstmid.wb_cyc", 32'(wb_cyc), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; ibus_req = 1'b0;
        chk_bus("rstmid", 1'b0, 1'b0, 4'h0, 32'h0);
        chk_pulses("rstmid", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstmid.ibus_rdata", ibus_rdata, 32'h0);
        slave_reply(1'b1, 1'b0, 32'hFEED_FACE);
        chk_pulses("late_ack", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("late_ack.wb_cyc", 32'(wb_cyc), 32'd0);
        chk("late_ack.ibus_rdata", ibus_rdata, 32'h0);
        slave_reply(1'b0, 1'b1, 32'h0);
        chk_pulses("late_err", 1'b0, 1'b0, 1'b0, 1'b0);
        $display("xfer reset mid-transfer");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
